// File: rtl/imager_pkg.sv
// imager_pkg: scheduler states, capture mode encodings and camera-select
// constants shared by the frame scheduler files.
package imager_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_TICK, ARM, START, WAIT_DONE} sched_state_t;
   localparam logic [1:0] MODE_CAM0 = 2'd0;
   localparam logic [1:0] MODE_CAM1 = 2'd1;
   localparam logic [1:0] MODE_ALT  = 2'd2;
   localparam logic [1:0] MODE_BOTH = 2'd3;
   localparam logic [1:0] CAM_SEL_0    = 2'b01;
   localparam logic [1:0] CAM_SEL_1    = 2'b10;
   localparam logic [1:0] CAM_SEL_BOTH = 2'b11;
   function automatic logic [1:0] cam_target(input logic [1:0] mode, input logic alt_cam1);
      return mode == MODE_CAM0 ? CAM_SEL_0 :
             mode == MODE_CAM1 ? CAM_SEL_1 :
             mode == MODE_ALT  ? (alt_cam1 ? CAM_SEL_1 : CAM_SEL_0) : CAM_SEL_BOTH;
   endfunction
endpackage

// File: rtl/frame_scheduler_interval_timer.sv
// interval_timer: period counter that raises tick on the last count of each
// period and restarts from 0; clear holds it at 0.
module interval_timer
   import imager_pkg::*;
#(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         run,
   input  logic         clear,
   input  logic [W-1:0] reload,
   output logic         tick
);
   logic [W-1:0] count;
   assign tick = run && count == reload;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) count <= '0;
      else if (clear) count <= '0;
      else if (run) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: periodic capture scheduler for two Stonyman camera pipelines.
// Define FRAME_SCHED_TIMEOUT_EN to enable the WAIT_DONE watchdog and camera reset pulses.
module frame_scheduler
   import imager_pkg::*;
#(
   parameter int INTERVAL_W  = 24,
   parameter int TIMEOUT_W   = 24,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [INTERVAL_W-1:0]  interval_counts,
   input  logic [TIMEOUT_W-1:0]   timeout_counts,
   input  logic                   clear_status,
   input  logic                   cam0_controller_busy,
   input  logic                   cam1_controller_busy,
   input  logic                   cam0_fifo_afull,
   input  logic                   cam1_fifo_afull,
   input  logic                   cam0_frame_capture_done,
   input  logic                   cam1_frame_capture_done,
   output logic                   cam0_frame_capture_start,
   output logic                   cam1_frame_capture_start,
   output logic                   cam0_reset,
   output logic                   cam1_reset,
   output logic                   sched_busy,
   output logic [1:0]             active_cam,
   output logic                   overrun,
   output logic                   timeout,
   output logic [FRAME_CNT_W-1:0] frame_count
);
   sched_state_t state;
   logic       tick, alt_cam1, complete, expire;
   logic [1:0] blocked, done_q, done_in, done_next, start_q, reset_q;
   interval_timer #(.W(INTERVAL_W)) u_timer (
      .clk(clk),
      .reset_n(reset_n),
      .run(enable && state != IDLE),
      .clear(state == IDLE),
      .reload(interval_counts),
      .tick(tick)
   );
   assign done_in    = {cam1_frame_capture_done, cam0_frame_capture_done};
   assign done_next  = done_q | (done_in & active_cam);
   assign complete   = (done_next & active_cam) == active_cam;
   assign sched_busy = state == ARM || state == START || state == WAIT_DONE;
   assign {cam1_frame_capture_start, cam0_frame_capture_start} = start_q;
   assign {cam1_reset, cam0_reset} = reset_q;
`ifdef FRAME_SCHED_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd;
   assign expire = state == WAIT_DONE && !complete && wd >= timeout_counts;
   // wd holds the number of WAIT_DONE cycles including the current one
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wd      <= '0;
         reset_q <= 2'b00;
         timeout <= 1'b0;
      end else begin
         wd      <= state == WAIT_DONE ? wd + 1'b1 : TIMEOUT_W'(1);
         reset_q <= expire ? active_cam & ~done_next : 2'b00;
         timeout <= expire ? 1'b1 : clear_status ? 1'b0 : timeout;
      end
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_counts;
   assign expire  = 1'b0;
   assign reset_q = 2'b00;
   assign timeout = 1'b0;
`endif
   // readiness is judged on the registered busy/afull of the previous cycle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state       <= IDLE;
         start_q     <= 2'b00;
         active_cam  <= 2'b00;
         alt_cam1    <= 1'b0;
         done_q      <= 2'b00;
         blocked     <= 2'b00;
         overrun     <= 1'b0;
         frame_count <= '0;
      end else begin
         start_q     <= 2'b00;
         blocked     <= {cam1_controller_busy | cam1_fifo_afull, cam0_controller_busy | cam0_fifo_afull};
         overrun     <= (tick && sched_busy) ? 1'b1 : clear_status ? 1'b0 : overrun;
         frame_count <= (state == WAIT_DONE && complete) ? frame_count + 1'b1 : clear_status ? '0 : frame_count;
         case (state)
            IDLE: state <= enable ? WAIT_TICK : IDLE;
            WAIT_TICK:
               if (!enable) state <= IDLE;
               else if (tick) begin
                  state      <= ARM;
                  active_cam <= cam_target(mode, alt_cam1);
                  alt_cam1   <= alt_cam1 ^ (mode == MODE_ALT);
               end
            ARM:
               if (!enable) state <= IDLE;
               else if (~|(active_cam & blocked)) begin
                  state   <= START;
                  start_q <= active_cam;
               end
            START: begin
               state  <= WAIT_DONE;
               done_q <= 2'b00;
            end
            WAIT_DONE: begin
               done_q <= done_next;
               if (complete || expire) state <= enable ? WAIT_TICK : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the scheduling rules.
module tb_frame_scheduler;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic        clear_status = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] interval_counts = 24'd0;
   logic [23:0] timeout_counts = 24'd0;
   logic [1:0]  busy = 2'b00;
   logic [1:0]  afull = 2'b00;
   logic [1:0]  done = 2'b00;
   logic [1:0]  start, cam_rst, active_cam;
   logic        sched_busy, overrun, timeout;
   logic [15:0] frame_count;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit          m_on, m_alt;
   int          m_stage, m_wc;
   longint      m_el;
   logic [1:0]  m_tgt, m_got, m_blk;
   logic [1:0]  e_start, e_rst, e_active;
   logic        e_over, e_to;
   logic [15:0] e_fc;
   int rc[2];
   int dly[2];
   int maxd = 25;
   bit spur = 1'b0;

   always #5 clk = ~clk;

   frame_scheduler dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .mode(mode),
      .interval_counts(interval_counts),
      .timeout_counts(timeout_counts),
      .clear_status(clear_status),
      .cam0_controller_busy(busy[0]),
      .cam1_controller_busy(busy[1]),
      .cam0_fifo_afull(afull[0]),
      .cam1_fifo_afull(afull[1]),
      .cam0_frame_capture_done(done[0]),
      .cam1_frame_capture_done(done[1]),
      .cam0_frame_capture_start(start[0]),
      .cam1_frame_capture_start(start[1]),
      .cam0_reset(cam_rst[0]),
      .cam1_reset(cam_rst[1]),
      .sched_busy(sched_busy),
      .active_cam(active_cam),
      .overrun(overrun),
      .timeout(timeout),
      .frame_count(frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_alt = 0; m_stage = -1; m_wc = 0; m_el = 0;
      m_tgt = 0; m_got = 0; m_blk = 0;
      e_start = 0; e_rst = 0; e_active = 0; e_over = 0; e_to = 0; e_fc = 0;
   endtask

   // stage: -1 waiting for a tick, 0 arming, 1 start pulse, 2 awaiting done
   task automatic model_step();
      bit tick, fin, exp_;
      if (!reset_n) begin
         model_reset();
         return;
      end
      e_start = 0; e_rst = 0; fin = 0; exp_ = 0;
      tick = m_on && enable && (m_el % (longint'(interval_counts) + 1) == longint'(interval_counts));
      if (m_on && enable) m_el++;
      if (tick && m_stage >= 0) e_over = 1; else if (clear_status) e_over = 0;
      if (m_stage == 2) begin
         m_got = m_got | (done & m_tgt);
         m_wc++;
         fin = m_got == m_tgt;
`ifdef FRAME_SCHED_TIMEOUT_EN
         exp_ = !fin && m_wc >= int'(timeout_counts);
`endif
      end
      if (fin) e_fc = e_fc + 16'd1; else if (clear_status) e_fc = 0;
      if (exp_) e_to = 1; else if (clear_status) e_to = 0;
      if (exp_) e_rst = m_tgt & ~m_got;
      if (!m_on) begin
         if (enable) m_on = 1;
      end else if (m_stage < 0) begin
         if (!enable) begin m_on = 0; m_el = 0; end
         else if (tick) begin
            case (mode)
               2'd0: m_tgt = 2'b01;
               2'd1: m_tgt = 2'b10;
               2'd2: begin m_tgt = m_alt ? 2'b10 : 2'b01; m_alt = !m_alt; end
               default: m_tgt = 2'b11;
            endcase
            e_active = m_tgt;
            m_stage = 0;
         end
      end else if (m_stage == 0) begin
         if (!enable) begin m_stage = -1; m_on = 0; m_el = 0; end
         else if ((m_tgt & m_blk) == 2'b00) begin m_stage = 1; e_start = m_tgt; end
      end else if (m_stage == 1) begin
         m_stage = 2; m_got = 0; m_wc = 0;
      end else if (fin || exp_) begin
         m_stage = -1;
         if (!enable) begin m_on = 0; m_el = 0; end
      end
      m_blk = busy | afull;
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) begin
         done[i] = (rc[i] == 1) || (spur && $urandom_range(0, 39) == 0);
         if (rc[i] > 0) rc[i]--;
      end
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("start", 32'(start), 32'(e_start));
      chk("cam_reset", 32'(cam_rst), 32'(e_rst));
      chk("active_cam", 32'(active_cam), 32'(e_active));
      chk("sched_busy", 32'(sched_busy), 32'(m_stage >= 0));
      chk("overrun", 32'(overrun), 32'(e_over));
      chk("timeout", 32'(timeout), 32'(e_to));
      chk("frame_count", 32'(frame_count), 32'(e_fc));
      for (int i = 0; i < 2; i++)
         if (start[i] && dly[i] != 0) rc[i] = (dly[i] < 0 ? int'($urandom_range(1, maxd)) : dly[i]) + 1;
   endtask

   task automatic wait_start(input string tag, input int lim, output int n);
      n = 0;
      do begin step(); n++; end while (start == 2'b00 && n < lim);
      chk({tag, "_seen"}, 32'(start != 2'b00), 32'd1);
   endtask

   task automatic settle();
      enable = 1'b0;
      for (int i = 0; i < 400 && (m_on || sched_busy); i++) step();
      step();
      chk("settle_idle", 32'(sched_busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_start"}, 32'(start), 32'd0);
      chk({tag, "_cam_reset"}, 32'(cam_rst), 32'd0);
      chk({tag, "_active"}, 32'(active_cam), 32'd0);
      chk({tag, "_busy"}, 32'(sched_busy), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
      chk({tag, "_count"}, 32'(frame_count), 32'd0);
   endtask

   initial begin
      int n, t0;
      logic [15:0] f0;
      logic [1:0] alt_exp [3];
      model_reset();
      rc = '{0, 0};
      dly = '{20, 20};
      #2 reset_n = 1'b0;
      #1 check_all_zero("rst");
      repeat (3) step();
      reset_n = 1'b1;

      // mode 0, 100-cycle period, 20-cycle captures
      mode = 2'd0; interval_counts = 24'd99; enable = 1'b1;
      wait_start("a0", 300, n);
      t0 = cyc;
      wait_start("a1", 300, n);
      chk("a_gap1", 32'(cyc - t0), 32'd100);
      t0 = cyc;
      wait_start("a2", 300, n);
      chk("a_gap2", 32'(cyc - t0), 32'd100);
      repeat (25) step();
      chk("a_frames", 32'(frame_count), 32'd3);
      chk("a_overrun", 32'(overrun), 32'd0);

      // alternate mode starts with cam0
      settle();
      mode = 2'd2; interval_counts = 24'd49; enable = 1'b1;
      alt_exp = '{2'b01, 2'b10, 2'b01};
      for (int i = 0; i < 3; i++) begin
         wait_start("b", 200, n);
         chk("b_active", 32'(active_cam), 32'(alt_exp[i]));
         chk("b_start", 32'(start), 32'(alt_exp[i]));
      end

      // both cameras, cam1 finishes 10 cycles after cam0
      settle();
      mode = 2'd3; interval_counts = 24'd199; dly = '{15, 25}; enable = 1'b1;
      wait_start("c", 300, n);
      chk("c_both", 32'(start), 32'd3);
      f0 = frame_count;
      n = 0;
      do begin step(); n++; end while (frame_count == f0 && n < 60);
      chk("c_latency", 32'(n), 32'd26);
      chk("c_inc", 32'(frame_count), 32'(f0 + 16'd1));
      repeat (5) step();
      chk("c_once", 32'(frame_count), 32'(f0 + 16'd1));

      // afull holds ARM; short interval overruns meanwhile
      settle();
      mode = 2'd0; interval_counts = 24'd9; dly = '{5, 5}; afull = 2'b01; enable = 1'b1;
      n = 0;
      do begin step(); n++; end while (!sched_busy && n < 50);
      chk("d_arm", 32'(sched_busy), 32'd1);
      repeat (30) step();
      chk("d_held", 32'(start), 32'd0);
      afull = 2'b00;
      n = 0;
      do begin step(); n++; end while (start == 2'b00 && n < 10);
      chk("d_delay", 32'(n), 32'd2);
      chk("d_overrun", 32'(overrun), 32'd1);

`ifdef FRAME_SCHED_TIMEOUT_EN
      // hung capture: watchdog resets cam0
      settle();
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      mode = 2'd0; interval_counts = 24'd999; timeout_counts = 24'd50; dly = '{0, 0}; enable = 1'b1;
      wait_start("e", 1100, n);
      f0 = frame_count;
      n = 0;
      do begin step(); n++; end while (cam_rst == 2'b00 && n < 100);
      chk("e_latency", 32'(n), 32'd51);
      chk("e_reset", 32'(cam_rst), 32'd1);
      chk("e_timeout", 32'(timeout), 32'd1);
      chk("e_count", 32'(frame_count), 32'(f0));
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      chk("e_cleared", 32'(timeout), 32'd0);
      maxd = 70;
`endif

      // reset during WAIT_DONE clears outputs at once
      settle();
      mode = 2'd0; interval_counts = 24'd99; dly = '{40, 40}; enable = 1'b1;
      wait_start("f", 300, n);
      repeat (10) step();
      chk("f_in_capture", 32'(sched_busy), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("f_async");
      model_reset();
      rc = '{0, 0};
      repeat (2) step();
      reset_n = 1'b1;
      wait_start("f_after", 200, n);
      chk("f_first", 32'(n), 32'd102);

      // randomized traffic
      spur = 1'b1;
      for (int b = 0; b < 24; b++) begin
         settle();
         mode = 2'($urandom_range(0, 3));
         interval_counts = 24'($urandom_range(2, 40));
         timeout_counts = 24'($urandom_range(15, 60));
         dly = '{-1, -1};
         enable = 1'b1;
         for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 2; i++) begin
               busy[i] = $urandom_range(0, 5) == 0;
               afull[i] = $urandom_range(0, 9) == 0;
            end
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            clear_status = $urandom_range(0, 49) == 0;
            enable = $urandom_range(0, 29) != 0;
            step();
         end
         clear_status = 1'b0;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Periodic frame-capture scheduler for the dual-Stonyman imager subsystem. It sits between the APB register block and the two camera pipelines (stonyman controller + ADC + framemask + pixel FIFO). It issues `camN_frame_capture_start` pulses at a programmed frame interval, either alternating between cameras or driving one or both. Before each start it checks the target's `controller_busy` and FIFO almost-full status, and it reports overruns and hung captures back to software.

## Interface
Parameters:
- `INTERVAL_W`, 24, width of frame-interval counter (clk ticks)
- `TIMEOUT_W`, 24, width of capture watchdog counter
- `FRAME_CNT_W`, 16, width of completed-frame counter

Ports:
- `clk` in 1: single clock for the whole block
- `reset_n` in 1: asynchronous active-low reset
- `enable` in 1: level; scheduling runs while high
- `mode` in 2: 0 = cam0 only, 1 = cam1 only, 2 = alternate (cam0 first), 3 = both simultaneous
- `interval_counts` in INTERVAL_W: frame period minus 1; 0 gives a tick every cycle
- `timeout_counts` in TIMEOUT_W: watchdog limit for WAIT_DONE
- `clear_status` in 1: one-cycle pulse, clears sticky flags and `frame_count`
- `cam0_controller_busy`, `cam1_controller_busy` in 1: camera sequencer busy
- `cam0_fifo_afull`, `cam1_fifo_afull` in 1: pixel FIFO almost full
- `cam0_frame_capture_done`, `cam1_frame_capture_done` in 1: one-cycle done pulses
- `cam0_frame_capture_start`, `cam1_frame_capture_start` out 1: one-cycle start pulses
- `cam0_reset`, `cam1_reset` out 1: one-cycle pulse on watchdog expiry
- `sched_busy` out 1: high in any state other than IDLE and WAIT_TICK
- `active_cam` out 2: one-hot target(s) of the current or last capture
- `overrun` out 1: sticky; a tick arrived while the previous capture was not finished
- `timeout` out 1: sticky; the watchdog expired
- `frame_count` out FRAME_CNT_W: completed captures, wraps to 0

## Operation
- States: IDLE, WAIT_TICK, ARM, START, WAIT_DONE.
- IDLE → WAIT_TICK when `enable` = 1. The interval counter loads 0 on entry.
- Interval counter: runs while `enable` = 1. When count == `interval_counts` it asserts `tick` and reloads 0.
- WAIT_TICK → ARM on `tick`. `active_cam` latches the target:
  - mode 0 → 01
  - mode 1 → 10
  - mode 2 → toggles each capture, first is 01
  - mode 3 → 11
- ARM → START once every targeted camera has `busy` = 0 and `afull` = 0. Otherwise ARM holds.
- START: asserts `camN_frame_capture_start` for each targeted camera for exactly 1 cycle, then → WAIT_DONE.
- WAIT_DONE: latches each done pulse per camera. When all targeted done bits are set:
  - `frame_count` increments by 1
  - the state goes to WAIT_TICK if `enable` = 1, else IDLE
- A `tick` in ARM, START or WAIT_DONE sets `overrun` and is dropped. Ticks are never queued.
- A done pulse from a non-targeted camera is ignored.
- `enable` falling:
  - in WAIT_TICK or ARM → IDLE next cycle; no start is issued
  - in START or WAIT_DONE → the capture completes, then IDLE
- `clear_status` coinciding with a flag set or a count increment: the set or increment wins.
- `mode` is sampled only on the WAIT_TICK → ARM transition. Mid-capture changes take effect on the next frame.

## Timing
- Reset value of every output is 0, including `active_cam` = 00. The alternate toggle resets to cam0.
- Tick to start pulse: 2 cycles (tick cycle → ARM → START) when the target is ready.
- Done pulse to `frame_count` update: 1 cycle.
- With mode 2 and `interval_counts` = N, each camera captures every 2(N+1) cycles.
- Asserting `reset_n` low mid-capture: all outputs clear immediately (asynchronously). No start is issued for 1 cycle after release.
- `frame_count` wraps from all-ones to 0 with no flag.

## Configuration
- `FRAME_SCHED_TIMEOUT_EN` defined:
  - the watchdog counts cycles spent in WAIT_DONE
  - when it reaches `timeout_counts`, each targeted camera whose done bit is not yet set gets a 1-cycle `camN_reset` pulse
  - `timeout` is set and `frame_count` is not incremented
  - the state goes to WAIT_TICK or IDLE as on a normal completion
- `FRAME_SCHED_TIMEOUT_EN` not defined:
  - WAIT_DONE waits indefinitely
  - `cam0_reset`, `cam1_reset` and `timeout` are tied to 0
  - `timeout_counts` is unused

## Structure
- Shared package `imager_pkg` holds:
  - the state enum
  - mode encodings (MODE_CAM0, MODE_CAM1, MODE_ALT, MODE_BOTH)
  - CAM_SEL one-hot constants
- One sub-module, `interval_timer`: a counter with a reload value and a `tick` output.
- The FSM, watchdog and status registers stay in `frame_scheduler`.

## Test plan
- Mode 0, `interval_counts` = 99, cam0 finishes 20 cycles after start → start pulses 100 cycles apart, `frame_count` = 3 after 3 frames, `overrun` = 0.
- Mode 2, interval 49 → starts alternate cam0, cam1, cam0; `active_cam` = 01, 10, 01.
- Mode 3, cam1 done 10 cycles after cam0 done → single `frame_count` increment, on the cycle after cam1 done.
- `cam0_fifo_afull` held high for 30 cycles in ARM → start delayed until 2 cycles after deassertion; an interval of 9 also sets `overrun`.
- With the macro defined, `timeout_counts` = 50 and no done pulse → `cam0_reset` pulses at WAIT_DONE cycle 50, `timeout` = 1, `frame_count` unchanged. `clear_status` then clears the flag.
- `reset_n` low during WAIT_DONE → all outputs 0 immediately. After release with `enable` = 1, the first start occurs after a full interval.
